branch_resolver: RTL and testbench

//  Execute-stage counterpart of the fetch-stage branch predictor. Holds every in-flight

---
 rtl/branch_resolver.sv | 154 +++++++++++++++
 tb/tb_branch_resolver.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: queues in-flight predictions in program order,
// checks them against ALU outcomes, and drives flush/redirect and counter training.
module branch_resolver #(
    parameter int unsigned ADDRESS_WIDTH = 22,
    parameter int unsigned INDEX_WIDTH   = 6,
    parameter int unsigned QUEUE_DEPTH   = 4,
    parameter int unsigned FLUSH_CYCLES  = 2
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset_n,
    input  logic                     i_IF_valid,
    input  logic [ADDRESS_WIDTH-1:0] i_IF_pc,
    input  logic                     i_IF_taken,
    input  logic [ADDRESS_WIDTH-1:0] i_IF_target,
    input  logic [1:0]               i_IF_counter,
    output logic                     o_IF_ready,
    input  logic                     i_EX_valid,
    input  logic                     i_EX_outcome,
    input  logic [ADDRESS_WIDTH-1:0] i_EX_target,
    output logic                     o_flush,
    output logic                     o_redirect_valid,
    output logic [ADDRESS_WIDTH-1:0] o_redirect_pc,
    output logic                     o_upd_valid,
    output logic [INDEX_WIDTH-1:0]   o_upd_index,
    output logic [1:0]               o_upd_counter,
    output logic [15:0]              o_mispredict_cnt,
    output logic                     o_err_underflow
);

    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] pc;
        logic                     taken;
        logic [ADDRESS_WIDTH-1:0] target;
        logic [1:0]               counter;
    } entry_t;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t            state;
    state_t            state_next;
    entry_t            queue [QUEUE_DEPTH];
    entry_t            head;
    logic [PTR_W-1:0]  head_ptr;
    logic [PTR_W-1:0]  tail_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [FC_W-1:0]   flush_cnt;
    logic              idle;
    logic              pop;
    logic              push;
    logic              miss;
    logic              underflow;
    logic              ready_next;
    logic [1:0]        new_counter;

    // Decode this cycle's push/pop/mispredict and the next queue occupancy.
    // A push is taken while full when the same cycle pops, keeping the queue full.
    always_comb begin
        head        = queue[head_ptr];
        idle        = (state == IDLE);
        pop         = i_EX_valid && idle && (count != '0);
        underflow   = i_EX_valid && idle && (count == '0);
        miss        = pop && ((i_EX_outcome != head.taken) ||
                              (i_EX_outcome && (i_EX_target != head.target)));
        push        = i_IF_valid && idle && !miss &&
                      ((count < CNT_W'(QUEUE_DEPTH)) || pop);
        new_counter = head.counter;
        if (i_EX_outcome) begin
            if (head.counter != 2'd3) new_counter = head.counter + 2'd1;
        end else begin
            if (head.counter != 2'd0) new_counter = head.counter - 2'd1;
        end
        count_next = count;
        if (miss) begin
            count_next = '0;
        end else begin
            count_next = count + CNT_W'(push) - CNT_W'(pop);
        end
        state_next = state;
        case (state)
            IDLE:    if (miss) state_next = FLUSH;
            FLUSH:   if (flush_cnt == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        ready_next = (count_next < CNT_W'(QUEUE_DEPTH)) && (state_next == IDLE);
    end

    // Prediction storage; contents are don't-care until written, so no reset.
    always_ff @(posedge i_Clk) begin
        if (push) begin
            queue[tail_ptr] <= '{pc: i_IF_pc, taken: i_IF_taken,
                                 target: i_IF_target, counter: i_IF_counter};
        end
    end

    // Control state, pointers and all registered outputs.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state            <= IDLE;
            head_ptr         <= '0;
            tail_ptr         <= '0;
            count            <= '0;
            flush_cnt        <= '0;
            o_IF_ready       <= 1'b0;
            o_flush          <= 1'b0;
            o_redirect_valid <= 1'b0;
            o_redirect_pc    <= '0;
            o_upd_valid      <= 1'b0;
            o_upd_index      <= '0;
            o_upd_counter    <= '0;
            o_mispredict_cnt <= '0;
            o_err_underflow  <= 1'b0;
        end else begin
            state            <= state_next;
            count            <= count_next;
            o_IF_ready       <= ready_next;
            o_err_underflow  <= underflow;
            o_upd_valid      <= pop;
            o_redirect_valid <= miss;
            if (pop) begin
                o_upd_index   <= head.pc[INDEX_WIDTH-1:0];
                o_upd_counter <= new_counter;
            end
            if (miss) begin
                o_redirect_pc <= i_EX_outcome ? i_EX_target
                                              : head.pc + ADDRESS_WIDTH'(1);
                if (o_mispredict_cnt != 16'hFFFF) begin
                    o_mispredict_cnt <= o_mispredict_cnt + 16'd1;
                end
                o_flush   <= 1'b1;
                flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
            end else if (state == FLUSH) begin
                if (flush_cnt == '0) begin
                    o_flush <= 1'b0;
                end else begin
                    flush_cnt <= flush_cnt - FC_W'(1);
                end
            end
            // Younger predictions are wrong-path after a mispredict: drop them all.
            if (miss) begin
                head_ptr <= '0;
                tail_ptr <= '0;
            end else begin
                if (pop)  head_ptr <= head_ptr + PTR_W'(1);
                if (push) tail_ptr <= tail_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver.
module tb_branch_resolver;

    localparam int unsigned AW = 22;
    localparam int unsigned IW = 6;

    logic          i_Clk = 1'b0;
    logic          i_Reset_n = 1'b1;
    logic          i_IF_valid = 1'b0;
    logic [AW-1:0] i_IF_pc = '0;
    logic          i_IF_taken = 1'b0;
    logic [AW-1:0] i_IF_target = '0;
    logic [1:0]    i_IF_counter = '0;
    logic          o_IF_ready;
    logic          i_EX_valid = 1'b0;
    logic          i_EX_outcome = 1'b0;
    logic [AW-1:0] i_EX_target = '0;
    logic          o_flush;
    logic          o_redirect_valid;
    logic [AW-1:0] o_redirect_pc;
    logic          o_upd_valid;
    logic [IW-1:0] o_upd_index;
    logic [1:0]    o_upd_counter;
    logic [15:0]   o_mispredict_cnt;
    logic          o_err_underflow;

    int total = 0;
    int bad   = 0;

    branch_resolver dut (
        .i_Clk            (i_Clk),
        .i_Reset_n        (i_Reset_n),
        .i_IF_valid       (i_IF_valid),
        .i_IF_pc          (i_IF_pc),
        .i_IF_taken       (i_IF_taken),
        .i_IF_target      (i_IF_target),
        .i_IF_counter     (i_IF_counter),
        .o_IF_ready       (o_IF_ready),
        .i_EX_valid       (i_EX_valid),
        .i_EX_outcome     (i_EX_outcome),
        .i_EX_target      (i_EX_target),
        .o_flush          (o_flush),
        .o_redirect_valid (o_redirect_valid),
        .o_redirect_pc    (o_redirect_pc),
        .o_upd_valid      (o_upd_valid),
        .o_upd_index      (o_upd_index),
        .o_upd_counter    (o_upd_counter),
        .o_mispredict_cnt (o_mispredict_cnt),
        .o_err_underflow  (o_err_underflow)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic cyc();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic set_if(input logic v, input logic [AW-1:0] pc, input logic tk,
                          input logic [AW-1:0] tgt, input logic [1:0] c);
        i_IF_valid   = v;
        i_IF_pc      = pc;
        i_IF_taken   = tk;
        i_IF_target  = tgt;
        i_IF_counter = c;
    endtask

    task automatic set_ex(input logic v, input logic oc, input logic [AW-1:0] tgt);
        i_EX_valid   = v;
        i_EX_outcome = oc;
        i_EX_target  = tgt;
    endtask

    initial begin
        // Reset
        #2 i_Reset_n = 1'b0;
        cyc();
        cyc();
        check("rst_ready", 32'(o_IF_ready), 32'd0);
        check("rst_flush", 32'(o_flush), 32'd0);
        check("rst_upd", 32'(o_upd_valid), 32'd0);
        check("rst_cnt", 32'(o_mispredict_cnt), 32'd0);
        i_Reset_n = 1'b1;
        cyc();
        check("ready_after_rst", 32'(o_IF_ready), 32'd1);

        // Correct taken prediction
        set_if(1'b1, 22'h10, 1'b1, 22'h40, 2'd2);
        cyc();
        set_if(1'b0, '0, 1'b0, '0, 2'd0);
        set_ex(1'b1, 1'b1, 22'h40);
        cyc();
        set_ex(1'b0, 1'b0, '0);
        check("hit_upd_valid", 32'(o_upd_valid), 32'd1);
        check("hit_upd_index", 32'(o_upd_index), 32'h10);
        check("hit_upd_ctr", 32'(o_upd_counter), 32'd3);
        check("hit_redirect", 32'(o_redirect_valid), 32'd0);
        check("hit_flush", 32'(o_flush), 32'd0);
        cyc();
        check("hit_upd_pulse", 32'(o_upd_valid), 32'd0);

        // Not-taken prediction resolves taken
        set_if(1'b1, 22'h05, 1'b0, 22'h0, 2'd1);
        cyc();
        set_if(1'b0, '0, 1'b0, '0, 2'd0);
        set_ex(1'b1, 1'b1, 22'h99);
        cyc();
        set_ex(1'b0, 1'b0, '0);
        check("mp1_redir_valid", 32'(o_redirect_valid), 32'd1);
        check("mp1_redir_pc", 32'(o_redirect_pc), 32'h99);
        check("mp1_flush_c0", 32'(o_flush), 32'd1);
        check("mp1_cnt", 32'(o_mispredict_cnt), 32'd1);
        check("mp1_upd_ctr", 32'(o_upd_counter), 32'd2);
        check("mp1_upd_index", 32'(o_upd_index), 32'h05);
        check("mp1_ready_c0", 32'(o_IF_ready), 32'd0);
        cyc();
        check("mp1_redir_pulse", 32'(o_redirect_valid), 32'd0);
        check("mp1_flush_c1", 32'(o_flush), 32'd1);
        check("mp1_ready_c1", 32'(o_IF_ready), 32'd0);
        cyc();
        check("mp1_flush_end", 32'(o_flush), 32'd0);
        check("mp1_ready_end", 32'(o_IF_ready), 32'd1);

        // Fill queue with four correct-path predictions
        for (int i = 0; i < 4; i++) begin
            set_if(1'b1, AW'(32'h21 + i), 1'b1, AW'(32'h100 + i), 2'(i));
            cyc();
        end
        check("full_ready", 32'(o_IF_ready), 32'd0);
        // Push while full with no pop is dropped
        set_if(1'b1, 22'h30, 1'b1, 22'h300, 2'd0);
        cyc();
        check("full_drop_ready", 32'(o_IF_ready), 32'd0);
        // Push and pop together while full
        set_if(1'b1, 22'h25, 1'b1, 22'h105, 2'd1);
        set_ex(1'b1, 1'b1, 22'h100);
        cyc();
        set_if(1'b0, '0, 1'b0, '0, 2'd0);
        check("pp_upd_index", 32'(o_upd_index), 32'h21);
        check("pp_upd_ctr", 32'(o_upd_counter), 32'd1);
        check("pp_redirect", 32'(o_redirect_valid), 32'd0);
        check("pp_ready", 32'(o_IF_ready), 32'd0);
        // Drain in order
        set_ex(1'b1, 1'b1, 22'h101);
        cyc();
        check("d0_index", 32'(o_upd_index), 32'h22);
        check("d0_ctr", 32'(o_upd_counter), 32'd2);
        check("d0_ready", 32'(o_IF_ready), 32'd1);
        set_ex(1'b1, 1'b1, 22'h102);
        cyc();
        check("d1_index", 32'(o_upd_index), 32'h23);
        check("d1_ctr", 32'(o_upd_counter), 32'd3);
        set_ex(1'b1, 1'b1, 22'h103);
        cyc();
        check("d2_index", 32'(o_upd_index), 32'h24);
        check("d2_ctr", 32'(o_upd_counter), 32'd3);
        set_ex(1'b1, 1'b1, 22'h105);
        cyc();
        check("d3_index", 32'(o_upd_index), 32'h25);
        check("d3_ctr", 32'(o_upd_counter), 32'd2);
        check("d3_redirect", 32'(o_redirect_valid), 32'd0);
        check("d3_cnt", 32'(o_mispredict_cnt), 32'd1);
        // Queue now empty: dropped entry never appears
        set_ex(1'b1, 1'b1, 22'h300);
        cyc();
        set_ex(1'b0, 1'b0, '0);
        check("drain_underflow", 32'(o_err_underflow), 32'd1);
        check("drain_no_upd", 32'(o_upd_valid), 32'd0);

        // Target mispredict with three entries queued
        for (int i = 0; i < 3; i++) begin
            set_if(1'b1, AW'(32'h31 + i), 1'b1, 22'h200, 2'd1);
            cyc();
        end
        set_if(1'b0, '0, 1'b0, '0, 2'd0);
        set_ex(1'b1, 1'b1, 22'h201);
        cyc();
        check("mp2_redir_pc", 32'(o_redirect_pc), 32'h201);
        check("mp2_cnt", 32'(o_mispredict_cnt), 32'd2);
        check("mp2_upd_ctr", 32'(o_upd_counter), 32'd2);
        check("mp2_flush", 32'(o_flush), 32'd1);
        // Inputs during flush are ignored
        set_ex(1'b1, 1'b1, 22'h200);
        set_if(1'b1, 22'h3A, 1'b1, 22'h200, 2'd1);
        cyc();
        set_ex(1'b0, 1'b0, '0);
        set_if(1'b0, '0, 1'b0, '0, 2'd0);
        check("fl_ign_upd", 32'(o_upd_valid), 32'd0);
        check("fl_ign_uflow", 32'(o_err_underflow), 32'd0);
        check("fl_c1_flush", 32'(o_flush), 32'd1);
        cyc();
        check("mp2_flush_end", 32'(o_flush), 32'd0);
        set_ex(1'b1, 1'b1, 22'h200);
        cyc();
        set_ex(1'b0, 1'b0, '0);
        check("mp2_underflow", 32'(o_err_underflow), 32'd1);
        check("mp2_uf_no_upd", 32'(o_upd_valid), 32'd0);
        check("mp2_uf_no_flush", 32'(o_flush), 32'd0);
        cyc();
        check("mp2_uf_pulse", 32'(o_err_underflow), 32'd0);

        // Fall-through wraps at the top of the address space
        set_if(1'b1, 22'h3FFFFF, 1'b1, 22'h123, 2'd0);
        cyc();
        set_if(1'b0, '0, 1'b0, '0, 2'd0);
        set_ex(1'b1, 1'b0, 22'h0);
        cyc();
        set_ex(1'b0, 1'b0, '0);
        check("wrap_redir_pc", 32'(o_redirect_pc), 32'h0);
        check("wrap_redir_valid", 32'(o_redirect_valid), 32'd1);
        check("wrap_ctr", 32'(o_upd_counter), 32'd0);
        check("wrap_index", 32'(o_upd_index), 32'h3F);
        check("wrap_cnt", 32'(o_mispredict_cnt), 32'd3);
        check("wrap_flush", 32'(o_flush), 32'd1);

        // Asynchronous reset during the first flush cycle
        #1 i_Reset_n = 1'b0;
        #1;
        check("arst_flush", 32'(o_flush), 32'd0);
        check("arst_ready", 32'(o_IF_ready), 32'd0);
        check("arst_cnt", 32'(o_mispredict_cnt), 32'd0);
        check("arst_redir", 32'(o_redirect_valid), 32'd0);
        cyc();
        i_Reset_n = 1'b1;
        cyc();
        check("arst_ready_after", 32'(o_IF_ready), 32'd1);
        check("arst_flush_after", 32'(o_flush), 32'd0);
        set_ex(1'b1, 1'b1, 22'h0);
        cyc();
        set_ex(1'b0, 1'b0, '0);
        check("arst_empty_uflow", 32'(o_err_underflow), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
